// File: rtl/ets_pkg.sv
// Shared state encoding, default sizes and timer sizing for the ETS sweep sequencer.
package ets_pkg;

    localparam int ETS_DATA_W         = 32;
    localparam int ETS_STEP_W         = 16;
    localparam int ETS_SETTLE_CYCLES  = 16;
    localparam int ETS_TIMEOUT_CYCLES = 65535;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACC_START,
        WAIT_ACC,
        EMIT,
        SHIFT,
        WAIT_SHIFT,
        DONE_EMPTY
    } ets_state_t;

    // The timer is loaded with count-1, so it only has to hold values below the larger count.
    function automatic int timer_width(input int settle, input int timeout);
        int max_count;
        max_count = (settle > timeout) ? settle : timeout;
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/ets_wait_timer.sv
// Loadable down-counter shared by the settle delay and the handshake timeouts.
module ets_wait_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ets_sweep_sequencer.sv
// Runs one equivalent-time sweep: settle, accumulate, stream the result, then request a phase shift,
// once per step.
module ets_sweep_sequencer
    import ets_pkg::*;
#(
    parameter int DATA_W         = ETS_DATA_W,
    parameter int STEP_W         = ETS_STEP_W,
    parameter int SETTLE_CYCLES  = ETS_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = ETS_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] num_steps,
    output logic              shift,
    input  logic              shift_done,
    output logic              acc_start,
    input  logic              acc_done,
    input  logic [DATA_W-1:0] acc_data,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              busy,
    output logic              sweep_done,
    output logic              timeout_err,
    output logic [STEP_W-1:0] step_idx
);

    localparam int TIMER_W = timer_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD  = TIMER_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    ets_state_t        state;
    ets_state_t        next_state;
    logic              start_q;
    logic              start_rise;
    logic              acc_armed;
    logic              handshake;
    logic              acc_capture;
    logic [STEP_W-1:0] n_reg;
    logic              timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic              timer_enable;
    logic              timer_expired;

    assign start_rise  = start && !start_q;
    assign handshake   = m_tvalid && m_tready;
    assign acc_capture = acc_armed && acc_done;

    // Every state change reloads the timer, so each settle or wait starts from a full count.
    assign timer_load   = (next_state != state);
    assign timer_value  = (next_state == SETTLE) ? SETTLE_LOAD : TIMEOUT_LOAD;
    assign timer_enable = (state == SETTLE) || (state == WAIT_ACC) || (state == WAIT_SHIFT);

    ets_wait_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (timer_enable),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:       if (start_rise) next_state = (num_steps == '0) ? DONE_EMPTY : SETTLE;
                SETTLE:     if (timer_expired) next_state = ACC_START;
                ACC_START:  next_state = WAIT_ACC;
                WAIT_ACC:   if (acc_capture) next_state = EMIT;
                            else if (timer_expired) next_state = IDLE;
                EMIT:       if (handshake) next_state = m_tlast ? IDLE : SHIFT;
                SHIFT:      next_state = WAIT_SHIFT;
                WAIT_SHIFT: if (shift_done) next_state = SETTLE;
                            else if (timer_expired) next_state = IDLE;
                DONE_EMPTY: next_state = IDLE;
                default:    next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        shift     = (state == SHIFT);
        acc_start = (state == ACC_START);
        busy      = (state != IDLE);
    end

    // WAIT_ACC is only ever entered from ACC_START, so this flag is low exactly in its first cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q   <= 1'b0;
            acc_armed <= 1'b0;
        end else begin
            start_q   <= start;
            acc_armed <= (state == WAIT_ACC);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_reg       <= '0;
            step_idx    <= '0;
            m_tdata     <= '0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            sweep_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (abort) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_rise) begin
                            n_reg       <= num_steps;
                            step_idx    <= '0;
                            timeout_err <= 1'b0;
                            sweep_done  <= (num_steps == '0);
                        end
                    end
                    WAIT_ACC: begin
                        if (acc_capture) begin
                            m_tdata  <= acc_data;
                            m_tvalid <= 1'b1;
                            m_tlast  <= (step_idx == n_reg - 1'b1);
                        end else if (timer_expired) begin
                            timeout_err <= 1'b1;
                            m_tvalid    <= 1'b0;
                        end
                    end
                    EMIT: begin
                        if (handshake) begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            if (m_tlast) begin
                                sweep_done <= 1'b1;
                            end else begin
                                step_idx <= step_idx + 1'b1;
                            end
                        end
                    end
                    WAIT_SHIFT: begin
                        if (!shift_done && timer_expired) begin
                            timeout_err <= 1'b1;
                            m_tvalid    <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ets_sweep_sequencer.sv
// Directed bench for the ETS sweep sequencer with a settle of 4 cycles and a 50-cycle timeout.
module tb_ets_sweep_sequencer;

    localparam int DATA_W  = 32;
    localparam int STEP_W  = 16;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 50;
    localparam int BUDGET  = 200;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [STEP_W-1:0] num_steps;
    logic              shift;
    logic              shift_done;
    logic              acc_start;
    logic              acc_done;
    logic [DATA_W-1:0] acc_data;
    logic              m_tvalid;
    logic              m_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;
    logic              busy;
    logic              sweep_done;
    logic              timeout_err;
    logic [STEP_W-1:0] step_idx;

    int tests = 0;
    int fails = 0;
    int shift_cnt = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    int tlast_cnt = 0;
    int shift_base;
    int done_base;
    int beat_base;
    int tlast_base;

    ets_sweep_sequencer #(
        .DATA_W         (DATA_W),
        .STEP_W         (STEP_W),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .num_steps   (num_steps),
        .shift       (shift),
        .shift_done  (shift_done),
        .acc_start   (acc_start),
        .acc_done    (acc_done),
        .acc_data    (acc_data),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .timeout_err (timeout_err),
        .step_idx    (step_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            if (shift) shift_cnt++;
            if (sweep_done) done_cnt++;
            if (m_tvalid && m_tready) begin
                beat_cnt++;
                if (m_tlast) tlast_cnt++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Produces a clean rising edge on start; returns at the negedge after the launch edge.
    task automatic applyStimulus(input logic [STEP_W-1:0] steps);
        start = 1'b0;
        tick();
        num_steps = steps;
        start = 1'b1;
        tick();
    endtask

    task automatic wait_acc_start(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (acc_start) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput({tag, "_acc_start_seen"}, 32'(found), 1);
    endtask

    task automatic wait_shift(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (shift) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput({tag, "_shift_seen"}, 32'(found), 1);
    endtask

    // Answers the next acc_start ten cycles later and checks the captured beat.
    task automatic capture_step(input string tag, input logic [DATA_W-1:0] data, input bit is_last);
        wait_acc_start(tag);
        repeat (10) tick();
        acc_done = 1'b1;
        acc_data = data;
        tick();
        acc_done = 1'b0;
        checkOutput({tag, "_tvalid"}, 32'(m_tvalid), 1);
        checkOutput({tag, "_tdata"}, m_tdata, data);
        checkOutput({tag, "_tlast"}, 32'(m_tlast), 32'(is_last));
    endtask

    task automatic answer_shift(input string tag);
        wait_shift(tag);
        repeat (2) tick();
        shift_done = 1'b1;
        tick();
        shift_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        num_steps = '0;
        shift_done = 1'b0;
        acc_done = 1'b0;
        acc_data = '0;
        m_tready = 1'b1;

        repeat (3) tick();
        checkOutput("rst_tvalid", 32'(m_tvalid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_tdata", m_tdata, 0);
        checkOutput("rst_step_idx", 32'(step_idx), 0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 0);
        checkOutput("rst_sweep_done", 32'(sweep_done), 0);
        reset = 1'b0;
        tick();

        // Three-step sweep, start held high throughout.
        shift_base = shift_cnt; done_base = done_cnt; beat_base = beat_cnt; tlast_base = tlast_cnt;
        applyStimulus(16'd3);
        checkOutput("s3_busy", 32'(busy), 1);
        repeat (3) tick();
        checkOutput("s3_acc_start_early", 32'(acc_start), 0);
        tick();
        checkOutput("s3_acc_start_latency", 32'(acc_start), 1);
        capture_step("s3_b0", 32'd100, 1'b0);
        checkOutput("s3_b0_step_idx", 32'(step_idx), 0);
        answer_shift("s3_b0");
        capture_step("s3_b1", 32'd200, 1'b0);
        answer_shift("s3_b1");
        capture_step("s3_b2", 32'd300, 1'b1);
        checkOutput("s3_b2_step_idx", 32'(step_idx), 2);
        tick();
        checkOutput("s3_sweep_done", 32'(sweep_done), 1);
        checkOutput("s3_busy_end", 32'(busy), 0);
        repeat (10) tick();
        checkOutput("s3_no_relaunch", 32'(busy), 0);
        checkOutput("s3_beats", 32'(beat_cnt - beat_base), 3);
        checkOutput("s3_tlast_count", 32'(tlast_cnt - tlast_base), 1);
        checkOutput("s3_shifts", 32'(shift_cnt - shift_base), 2);
        checkOutput("s3_done_count", 32'(done_cnt - done_base), 1);

        // Backpressure on the first beat, plus a start edge arriving mid-sweep.
        shift_base = shift_cnt; done_base = done_cnt; beat_base = beat_cnt;
        m_tready = 1'b0;
        applyStimulus(16'd2);
        capture_step("bp_b0", 32'd555, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) start = 1'b0;
            if (i == 8) start = 1'b1;
            tick();
            checkOutput("bp_hold_tvalid", 32'(m_tvalid), 1);
            checkOutput("bp_hold_tdata", m_tdata, 32'd555);
        end
        checkOutput("bp_no_shift", 32'(shift_cnt - shift_base), 0);
        checkOutput("bp_step_idx_held", 32'(step_idx), 0);
        m_tready = 1'b1;
        tick();
        checkOutput("bp_tvalid_dropped", 32'(m_tvalid), 0);
        answer_shift("bp_b0");
        capture_step("bp_b1", 32'd666, 1'b1);
        tick();
        checkOutput("bp_sweep_done", 32'(sweep_done), 1);
        repeat (5) tick();
        checkOutput("bp_beats", 32'(beat_cnt - beat_base), 2);
        checkOutput("bp_done_count", 32'(done_cnt - done_base), 1);
        checkOutput("bp_idle", 32'(busy), 0);

        // Zero-step launch.
        beat_base = beat_cnt;
        applyStimulus(16'd0);
        checkOutput("z_sweep_done", 32'(sweep_done), 1);
        checkOutput("z_busy", 32'(busy), 1);
        tick();
        checkOutput("z_sweep_done_clear", 32'(sweep_done), 0);
        checkOutput("z_busy_clear", 32'(busy), 0);
        checkOutput("z_beats", 32'(beat_cnt - beat_base), 0);

        // Shift acknowledge never returned.
        done_base = done_cnt;
        applyStimulus(16'd2);
        capture_step("to_b0", 32'd500, 1'b0);
        wait_shift("to");
        repeat (50) tick();
        checkOutput("to_still_waiting", 32'(busy), 1);
        checkOutput("to_err_not_yet", 32'(timeout_err), 0);
        tick();
        checkOutput("to_idle", 32'(busy), 0);
        checkOutput("to_err_set", 32'(timeout_err), 1);
        checkOutput("to_tvalid", 32'(m_tvalid), 0);
        repeat (3) tick();
        checkOutput("to_no_sweep_done", 32'(done_cnt - done_base), 0);
        applyStimulus(16'd1);
        checkOutput("to_err_cleared", 32'(timeout_err), 0);
        capture_step("to_relaunch", 32'd42, 1'b1);
        tick();
        checkOutput("to_relaunch_done", 32'(sweep_done), 1);

        // Abort during WAIT_ACC of step 1 of a 4-step sweep.
        applyStimulus(16'd4);
        capture_step("ab_b0", 32'd11, 1'b0);
        answer_shift("ab_b0");
        wait_acc_start("ab_b1");
        tick();
        beat_base = beat_cnt; done_base = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("ab_idle", 32'(busy), 0);
        checkOutput("ab_tvalid", 32'(m_tvalid), 0);
        checkOutput("ab_err_unchanged", 32'(timeout_err), 0);
        repeat (3) tick();
        acc_done = 1'b1;
        acc_data = 32'd999;
        tick();
        acc_done = 1'b0;
        tick();
        checkOutput("ab_late_done_ignored", 32'(m_tvalid), 0);
        checkOutput("ab_no_beat", 32'(beat_cnt - beat_base), 0);
        checkOutput("ab_no_sweep_done", 32'(done_cnt - done_base), 0);
        shift_base = shift_cnt; beat_base = beat_cnt; done_base = done_cnt;
        applyStimulus(16'd4);
        capture_step("ab_r0", 32'd1, 1'b0);
        answer_shift("ab_r0");
        capture_step("ab_r1", 32'd2, 1'b0);
        answer_shift("ab_r1");
        capture_step("ab_r2", 32'd3, 1'b0);
        answer_shift("ab_r2");
        capture_step("ab_r3", 32'd4, 1'b1);
        checkOutput("ab_r3_step_idx", 32'(step_idx), 3);
        repeat (3) tick();
        checkOutput("ab_r_beats", 32'(beat_cnt - beat_base), 4);
        checkOutput("ab_r_shifts", 32'(shift_cnt - shift_base), 3);
        checkOutput("ab_r_done", 32'(done_cnt - done_base), 1);

        // acc_done already high before acc_start: only captured from the second WAIT_ACC cycle.
        acc_done = 1'b1;
        acc_data = 32'd77;
        applyStimulus(16'd1);
        wait_acc_start("st");
        tick();
        checkOutput("st_first_cycle", 32'(m_tvalid), 0);
        tick();
        checkOutput("st_not_sampled", 32'(m_tvalid), 0);
        tick();
        checkOutput("st_captured", 32'(m_tvalid), 1);
        checkOutput("st_tdata", m_tdata, 32'd77);
        checkOutput("st_tlast", 32'(m_tlast), 1);
        acc_done = 1'b0;
        tick();
        checkOutput("st_sweep_done", 32'(sweep_done), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ets_sweep_sequencer.md
Name: ets_sweep_sequencer

Overview:
Sequences one equivalent-time-sampling sweep on the sample clock domain. Per phase step it settles, runs one static-counter accumulation, and emits the result as one AXI-Stream word. It then commands one fine phase shift of the clock source. The block sits between the AXI-Lite control registers, the phase-shift handshake of the clock-source block, the ETS adder, and the CDC FIFO slave port.

Parameters:
DATA_W, 32, width of accumulator result and stream data
STEP_W, 16, width of step counter / configured step count
SETTLE_CYCLES, 16, idle cycles after every shift before accumulation starts
TIMEOUT_CYCLES, 65535, maximum wait for shift_done or acc_done before abort

Ports:
clk  in  1  sample clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  level from control register; rising edge launches a sweep
abort  in  1  synchronous abort request; any state -> IDLE
num_steps  in  STEP_W  steps per sweep; latched on launch
shift  out  1  one-cycle phase-shift request to clock source
shift_done  in  1  clock source acknowledge, one-cycle pulse
acc_start  out  1  one-cycle start pulse to ETS adder
acc_done  in  1  adder completion (level or pulse)
acc_data  in  DATA_W  adder result, valid while acc_done high
m_tvalid  out  1  stream valid
m_tready  in  1  stream ready
m_tdata  out  DATA_W  accumulated count for current step
m_tlast  out  1  high on final step word
busy  out  1  high in every state except IDLE
sweep_done  out  1  one-cycle pulse on normal sweep completion
timeout_err  out  1  sticky error; cleared on next launch
step_idx  out  STEP_W  index of the step being processed

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0; start edge register 0.
- Launch: a rising edge of start (start=1, previous start=0) in IDLE. On launch: latch num_steps into n_reg; clear timeout_err; step_idx=0; go to SETTLE.
  - If num_steps==0: no stream beats; sweep_done pulses the following cycle; return to IDLE.
  - Rising edges of start outside IDLE are ignored.
- SETTLE: count SETTLE_CYCLES cycles, then go to ACC_START.
- ACC_START: acc_start=1 for exactly 1 cycle; go to WAIT_ACC.
- WAIT_ACC:
  - acc_done is not sampled in the first cycle of this state, so a stale done level is ignored.
  - From the next cycle, acc_done=1 captures acc_data into m_tdata. In the same edge, m_tvalid=1, m_tlast=(step_idx==n_reg-1), and the FSM goes to EMIT.
- EMIT:
  - m_tdata, m_tvalid and m_tlast are held stable until m_tvalid&&m_tready.
  - On handshake, if last: sweep_done pulses, go to IDLE.
  - Otherwise: step_idx+1, go to SHIFT.
  - m_tvalid never drops without a handshake except on abort or reset.
- SHIFT: shift=1 for 1 cycle; go to WAIT_SHIFT.
- WAIT_SHIFT: shift_done=1 -> SETTLE. A shift_done seen in any other state is ignored.
- Timeout:
  - In WAIT_ACC and WAIT_SHIFT a cycle counter runs.
  - Reaching TIMEOUT_CYCLES sets timeout_err=1, drops m_tvalid, goes to IDLE, and produces no sweep_done.
  - The counter clears on every state entry.
- Abort:
  - abort=1 forces IDLE on the next edge and clears m_tvalid, m_tlast, shift and acc_start.
  - Abort has priority over all transitions, including a simultaneous handshake; timeout_err is unchanged.
  - If the stream handshake completes in that same cycle, the beat counts as delivered.
- Latency, launch to first acc_start: 1 + SETTLE_CYCLES + 1 cycles.
  - With SETTLE_CYCLES=0, SETTLE lasts 1 cycle.
- Step count: exactly n_reg beats and n_reg-1 shift pulses per sweep; the step_idx width wrap is unreachable because step_idx < n_reg.
- Reset mid-sweep: all state is lost immediately. The external phase is not restored; software reprograms it.

Decomposition:
- Shared package ets_pkg holds:
  - FSM state enum: IDLE, SETTLE, ACC_START, WAIT_ACC, EMIT, SHIFT, WAIT_SHIFT, DONE_EMPTY.
  - Default widths and timeout constant.
- One sub-module, ets_wait_timer: loadable down-counter with expired flag, reused for the settle and timeout counts.
- The FSM, stream output register and counters stay in the top.

Test Plan:
- Sweep of 3 steps (num_steps=3, SETTLE_CYCLES=4), acc_done 10 cycles after each acc_start with acc_data=100,200,300, tready=1 -> beats 100,200,300; tlast only on 300; exactly 2 shift pulses; one sweep_done.
- Backpressure: num_steps=2, tready=0 for 20 cycles on beat 0 -> tdata=first value held stable with tvalid=1 throughout; no shift before the handshake.
- num_steps=0 launch -> zero beats; sweep_done 1 cycle after launch; busy low afterwards.
- Timeout: TIMEOUT_CYCLES=50, shift_done never returned -> timeout_err=1 after 50 WAIT_SHIFT cycles; FSM IDLE; no sweep_done; the next launch clears timeout_err.
- Abort asserted during WAIT_ACC of step 1 of 4 -> IDLE next cycle; tvalid=0; the later acc_done is ignored; a new start edge runs a full 4-step sweep.
- Start held high through sweep completion -> no relaunch. A start edge arriving mid-sweep is ignored.
- acc_done stuck high before acc_start -> not captured in the first WAIT_ACC cycle; captured from the second cycle.
